// File: rtl/freelist_pkg.sv
// Shared sizing, pointer type and pointer arithmetic helpers for the rename free list.
// The pointer helpers are kept generic enough for the ROB to reuse.
package freelist_pkg;

    localparam int PREG_NUM       = 64;
    localparam int LREG_NUM       = 32;
    localparam int FREELIST_DEPTH = PREG_NUM - LREG_NUM;

    localparam int PREG_W         = $clog2(PREG_NUM);
    localparam int FREELIST_IDX_W = $clog2(FREELIST_DEPTH);

    typedef logic [PREG_W-1:0]         preg_t;
    typedef logic [FREELIST_IDX_W-1:0] fl_idx_t;
    typedef logic [FREELIST_IDX_W:0]   fl_count_t;

    // The wrap bit distinguishes a full queue from an empty one when the indices are equal.
    typedef struct packed {
        logic    wrap;
        fl_idx_t idx;
    } freelist_ptr_t;

    function automatic freelist_ptr_t ptr_add(input freelist_ptr_t p, input logic [1:0] n);
        logic [FREELIST_IDX_W:0] s;
        s = p + {{(FREELIST_IDX_W-1){1'b0}}, n};
        return s;
    endfunction

    // Occupancy between two pointers, modulo twice the depth.
    function automatic fl_count_t ptr_dist(input freelist_ptr_t a, input freelist_ptr_t b);
        return {a.wrap, a.idx} - {b.wrap, b.idx};
    endfunction

endpackage

// File: rtl/freelist_if.sv
// Rename/commit/flush bundle of the physical-register free list.
// master = pipeline side (rename + commit), slave = the free list itself.
interface freelist_if;
    import freelist_pkg::*;

    logic      instr0_freelist_req;
    preg_t     instr0_freelist_resp;
    logic      instr1_freelist_req;
    preg_t     instr1_freelist_resp;
    logic      freelist_can_alloc;
    logic      commit0_valid;
    preg_t     commit0_old_prd;
    logic      commit1_valid;
    preg_t     commit1_old_prd;
    logic      flush_valid;
    fl_count_t freelist_count;

    modport master (
        output instr0_freelist_req,
        output instr1_freelist_req,
        output commit0_valid,
        output commit0_old_prd,
        output commit1_valid,
        output commit1_old_prd,
        output flush_valid,
        input  instr0_freelist_resp,
        input  instr1_freelist_resp,
        input  freelist_can_alloc,
        input  freelist_count
    );

    modport slave (
        input  instr0_freelist_req,
        input  instr1_freelist_req,
        input  commit0_valid,
        input  commit0_old_prd,
        input  commit1_valid,
        input  commit1_old_prd,
        input  flush_valid,
        output instr0_freelist_resp,
        output instr1_freelist_resp,
        output freelist_can_alloc,
        output freelist_count
    );

endinterface

// File: rtl/freelist_ptr.sv
// Circular queue pointer (index plus wrap bit) advancing by 0..2 per cycle,
// with a one-cycle load used for rewinding.
module freelist_ptr #(
    parameter int               PTR_W   = 6,
    parameter logic [PTR_W-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else begin
            q <= q + PTR_W'(inc);
        end
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: grants up to two pregs per cycle to rename, takes back
// up to two released pregs per cycle from commit, and rewinds speculative grants on flush.
module freelist #(
    parameter int PREG_NUM = freelist_pkg::PREG_NUM,
    parameter int LREG_NUM = freelist_pkg::LREG_NUM,
    parameter int DEPTH    = freelist_pkg::FREELIST_DEPTH
) (
    input  logic      clock,
    input  logic      reset,
    freelist_if.slave fl
);
    import freelist_pkg::*;

    localparam int PREG_W_L = $clog2(PREG_NUM);
    localparam int PTR_W    = FREELIST_IDX_W + 1;

    logic [PREG_W_L-1:0] entry_q [DEPTH];

    freelist_ptr_t head_q;
    freelist_ptr_t arch_head_q;
    freelist_ptr_t arch_head_next;
    freelist_ptr_t tail_q;

    logic       req0;
    logic       req1;
    logic       v0;
    logic       v1;
    logic       flush;
    logic [1:0] n_alloc;
    logic [1:0] n_free;
    fl_idx_t    head_idx1;
    fl_idx_t    tail_idx1;
    fl_count_t  count;

    assign req0  = fl.instr0_freelist_req;
    assign req1  = fl.instr1_freelist_req;
    assign v0    = fl.commit0_valid;
    assign v1    = fl.commit1_valid;
    assign flush = fl.flush_valid;

    assign n_alloc = {1'b0, req0} + {1'b0, req1};
    assign n_free  = {1'b0, v0} + {1'b0, v1};

    assign head_idx1 = head_q.idx + fl_idx_t'(1);
    assign tail_idx1 = tail_q.idx + fl_idx_t'(1);

    // Grants are read straight from the current head; frees written this cycle
    // only become visible after the edge.
    assign count                   = ptr_dist(tail_q, head_q);
    assign fl.freelist_count       = count;
    assign fl.freelist_can_alloc   = (count >= fl_count_t'(2));
    assign fl.instr0_freelist_resp = entry_q[head_q.idx];
    assign fl.instr1_freelist_resp = req0 ? entry_q[head_idx1] : entry_q[head_q.idx];

    // A flush rewinds to the committed allocation point, including any commits
    // retiring in the same cycle.
    assign arch_head_next = ptr_add(arch_head_q, n_free);

    freelist_ptr #(
        .PTR_W   (PTR_W),
        .RST_VAL ('0)
    ) u_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (n_alloc),
        .load     (flush),
        .load_val (arch_head_next),
        .q        (head_q)
    );

    freelist_ptr #(
        .PTR_W   (PTR_W),
        .RST_VAL ('0)
    ) u_arch_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (n_free),
        .load     (1'b0),
        .load_val ('0),
        .q        (arch_head_q)
    );

    freelist_ptr #(
        .PTR_W   (PTR_W),
        .RST_VAL (PTR_W'(DEPTH))
    ) u_tail (
        .clock    (clock),
        .reset    (reset),
        .inc      (n_free),
        .load     (1'b0),
        .load_val ('0),
        .q        (tail_q)
    );

    // Slot 0 lands at tail, slot 1 behind it; a lone slot 1 lands at tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PREG_W_L'(LREG_NUM + i);
            end
        end else begin
            if (v0) begin
                entry_q[tail_q.idx] <= fl.commit0_old_prd;
            end
            if (v1) begin
                entry_q[v0 ? tail_idx1 : tail_q.idx] <= fl.commit1_old_prd;
            end
        end
    end

    alloc_within_count: assert property (@(posedge clock) disable iff (reset)
        !flush |-> ({{(FREELIST_IDX_W-1){1'b0}}, n_alloc} <= count));

    free_within_depth: assert property (@(posedge clock) disable iff (reset)
        (32'(count) + 32'(n_free)) <= 32'(DEPTH));

endmodule
